cnt_mod_updown: RTL

Parametrised modulo up/down counter with a built-in prescaler, synchronous clear, parallel load and wrap signalling. It generalises the fixed 4-bit free-running counter used in the day-level exercise designs: width, modulus and count rate are configurable, and direction is selectable at run time. It is intended as the common timebase and event counter for the small timer, divider and display-scan blocks in the same design set.

---
 rtl/cnt_mod_updown_if.sv | 42 ++++
 rtl/cnt_mod_updown.sv | 92 +++++++++
 2 files changed

// File: rtl/cnt_mod_updown_if.sv
`default_nettype none
// ============================================================================
// Module   : cnt_mod_updown_if
// Purpose  : Control/status bundle for the modulo up/down counter.
//            The master side (timer, divider or scan block) drives the
//            control lines and observes the count and event pulses.
//            The slave side is the counter itself.
// Signals  : en        - count enable, advances the prescaler
//            up        - direction, 1 = increment, 0 = decrement
//            clr       - synchronous clear of count and prescaler
//            load      - synchronous parallel load
//            load_val  - value to load (WIDTH bits)
//            o_cnt     - current count (WIDTH bits, registered)
//            o_tc      - terminal count for the current direction (comb.)
//            o_wrap    - one-cycle pulse after a wrapping step
//            o_load_err- one-cycle pulse after an out-of-range load
// Revision : 1.0  initial release
// ============================================================================
interface cnt_mod_updown_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] o_cnt;
    logic             o_tc;
    logic             o_wrap;
    logic             o_load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  o_cnt, o_tc, o_wrap, o_load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output o_cnt, o_tc, o_wrap, o_load_err
    );
endinterface
`default_nettype wire

// File: rtl/cnt_mod_updown.sv
`default_nettype none
// ============================================================================
// Module   : cnt_mod_updown
// Purpose  : Parametrised modulo up/down counter with prescaler, synchronous
//            clear, parallel load and wrap signalling. Counts 0..MOD-1 and
//            takes one step every PRESCALE enabled cycles.
// Params   : WIDTH    - count width, must hold the modulus (MOD <= 2**WIDTH)
//            modulus  - parameter MOD, at least 2
//            prescale - parameter PRESCALE, enabled cycles per step, >= 1
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset
//            bus      - control/status bundle (slave modport)
// Revision : 1.0  initial release
// ============================================================================
module cnt_mod_updown #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cnt_mod_updown_if.slave bus
);

    // Prescaler is at least one bit wide; with PRESCALE=1 it simply stays 0.
    localparam int                c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  c_CNT_MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0]  r_cnt;
    logic [c_PS_W-1:0] r_ps;
    logic              r_wrap;
    logic              r_load_err;

    logic              w_tc;
    logic              w_ps_last;
    logic              w_load_oor;
    logic [WIDTH-1:0]  w_cnt_inc;
    logic [WIDTH-1:0]  w_cnt_dec;

    // Terminal count doubles as the "this step wraps" condition.
    assign w_tc      = bus.up ? (r_cnt == c_CNT_MAX) : (r_cnt == '0);
    assign w_ps_last = (r_ps == c_PS_LAST);

    // One extra bit keeps the range check correct when MOD = 2**WIDTH.
    assign w_load_oor = ({1'b0, bus.load_val} > {1'b0, c_CNT_MAX});

    // Explicit wrap at both ends so the count never leaves 0..MOD-1,
    // independent of whether MOD fills the register.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + WIDTH'(1);
    assign w_cnt_dec = (r_cnt == '0) ? c_CNT_MAX : r_cnt - WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_ps       <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            // Event pulses default low so they never outlast one cycle.
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (bus.clr) begin
                r_cnt <= '0;
                r_ps  <= '0;
            end else if (bus.load) begin
                r_ps <= '0;
                if (w_load_oor) begin
                    r_cnt      <= c_CNT_MAX;
                    r_load_err <= 1'b1;
                end else begin
                    r_cnt <= bus.load_val;
                end
            end else if (bus.en) begin
                if (w_ps_last) begin
                    r_ps   <= '0;
                    r_cnt  <= bus.up ? w_cnt_inc : w_cnt_dec;
                    r_wrap <= w_tc;
                end else begin
                    r_ps <= r_ps + c_PS_W'(1);
                end
            end
        end
    end

    assign bus.o_cnt      = r_cnt;
    assign bus.o_tc       = w_tc;
    assign bus.o_wrap     = r_wrap;
    assign bus.o_load_err = r_load_err;

endmodule
`default_nettype wire
